fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one FIFO_SYNC instance (8x8 default) among N_REQ producers.
- Each producer uses a valid/ready handshake and may send a burst that is terminated by `last`.
- The block keeps its own credit count of free FIFO slots, so it never overflows the FIFO, even though the FIFO full flag lags by one cycle.
- It sits between the producer blocks and the FIFO write port; the consumer reports every successful pop back to it.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, data width; must equal the FIFO width.
- FIFO_DEPTH, 8, depth of the attached FIFO; sets the initial credit count.
- MAX_BURST, 4, maximum beats per grant before a forced release (1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester beat valid
- req_data  in  N_REQ*DATA_W  per-requester data; requester i occupies bits [i*DATA_W +: DATA_W]
- req_last  in  N_REQ  final beat of the requester's burst
- req_ready  out  N_REQ  per-requester accept, combinational
- fifo_wr_en  out  1  FIFO write strobe, registered
- fifo_d_in  out  DATA_W  FIFO write data, registered
- fifo_rd_pop  in  1  one-cycle pulse per actual FIFO read (rd_en & ~empty)
- grant_valid  out  1  a burst grant is active
- grant_id  out  clog2(N_REQ)  index of the granted requester
- credit_cnt  out  clog2(FIFO_DEPTH)+1  free FIFO slots
- err_pop  out  1  sticky error: a pop arrived while credit_cnt == FIFO_DEPTH

Behaviour:
- Reset (async, active-low):
  - state = IDLE, rr_ptr = 0, beat_cnt = 0.
  - credit_cnt = FIFO_DEPTH.
  - grant_valid = 0, grant_id = 0.
  - fifo_wr_en = 0, fifo_d_in = 0, err_pop = 0, req_ready = 0.
  - A reset mid-burst drops the grant, and any pending output write is cancelled.
- FSM states: IDLE, BURST.
- IDLE:
  - req_ready = 0.
  - If any req_valid is set, the winner is the first set bit searching from rr_ptr upward, with wrap-around.
  - Next cycle: state = BURST, grant_id = winner, grant_valid = 1, beat_cnt = 0.
  - Arbitration does not depend on credits.
- BURST:
  - req_ready[grant_id] = (credit_cnt != 0). All other ready bits are 0.
  - A transfer occurs when req_valid[grant_id] & req_ready[grant_id].
  - On a transfer, next cycle: fifo_wr_en = 1 and fifo_d_in = that requester's data slice. Latency is exactly 1 cycle.
  - On a transfer, beat_cnt is incremented. Otherwise fifo_wr_en = 0.
- Burst end: a transfer with req_last = 1, or a transfer where beat_cnt+1 == MAX_BURST, causes:
  - state = IDLE, grant_valid = 0, rr_ptr = (grant_id+1) mod N_REQ.
  - The minimum gap between bursts is one IDLE cycle.
- Stalls:
  - If the granted requester deasserts valid, the grant is held; there is no timeout.
  - If credits are 0, ready = 0 and the grant is held until a pop arrives.
- Credits:
  - Transfer only: credit_cnt decrements.
  - fifo_rd_pop only: credit_cnt increments.
  - Both in the same cycle: credit_cnt is unchanged.
  - A pop while credit_cnt == FIFO_DEPTH is ignored (no wrap) and sets err_pop. Only reset clears err_pop.
- Invariant: credit_cnt + FIFO occupancy == FIFO_DEPTH, with occupancy counted after the 1-cycle write latency. The FIFO full flag is not used.
- Non-granted requesters must hold their data stable while valid is high (standard handshake).

Decomposition:
- Package fifo_arb_pkg:
  - state enum {IDLE, BURST}.
  - Widths REQ_IDX_W = clog2(N_REQ) and CRED_W = clog2(FIFO_DEPTH)+1.
  - Default constants.
- Sub-module rr_pick (combinational):
  - Inputs: request vector and rr_ptr.
  - Outputs: winner index and any-request flag.
  - Implemented as a rotate, priority-encode, un-rotate.
- The credit counter, FSM and output register stay in fifo_wr_arbiter.

Test Plan:
- Single requester: req0 sends a 3-beat burst (0x11, 0x22, 0x33 with last on 0x33), consumer idle.
  - Required: grant_id = 0, fifo_wr_en high for 3 cycles, each one cycle after its transfer.
  - Required: credit_cnt goes 8→5; IDLE follows.
- Round robin: req0..req3 all valid with 1-beat bursts (last = 1).
  - Required: grant order 0, 1, 2, 3, 0.
  - Required: each grant is separated by one IDLE cycle.
- Credit exhaustion: req1 streams 10 beats with no pops and MAX_BURST = 255.
  - Required: exactly 8 writes, then req_ready = 0 and credit_cnt = 0.
  - Then one fifo_rd_pop pulse → exactly one more write, credit_cnt back to 0, no FIFO overflow.
- Forced release: req2 holds valid with last = 0 and req3 is valid, MAX_BURST = 4.
  - Required: 4 beats from req2, then the grant passes to req3.
- Simultaneous transfer and pop at credit_cnt = 3: credit_cnt stays 3.
  - Follow-up: a pop at credit_cnt = 8 → credit_cnt stays 8 and err_pop = 1 (sticky).
- Reset mid-burst: assert rst_n = 0 after 2 of 4 beats.
  - Required: all outputs take reset values immediately and credit_cnt = 8.
  - Required: after release, arbitration restarts from rr_ptr = 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

    // Arbiter control states: waiting for a request, or serving one burst.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_MAX_BURST  = 4;

    // Widths for the default configuration.
    localparam int REQ_IDX_W = $clog2(DEF_N_REQ);
    localparam int CRED_W    = $clog2(DEF_FIFO_DEPTH) + 1;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake bundle plus the FIFO write/pop side of the arbiter.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    fifo_wr_en;
    logic [DATA_W-1:0]       fifo_d_in;
    logic                    fifo_rd_pop;

    // Producers and the consumer's pop report drive the arbiter.
    modport master (
        output req_valid, req_data, req_last, fifo_rd_pop,
        input  req_ready, fifo_wr_en, fifo_d_in
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_data, req_last, fifo_rd_pop,
        output req_ready, fifo_wr_en, fifo_d_in
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin winner selection: rotate so rr_ptr sits at bit 0, take the
// lowest set bit, then rotate the index back.
module fifo_wr_arbiter_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = $clog2(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);
    localparam logic [IDX_W:0] N_WIDE = (IDX_W+1)'(N_REQ);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;
    logic [IDX_W:0]     sum;

    // Rotate, priority-encode, un-rotate.
    always_comb begin
        dbl     = {req, req};
        rot     = dbl[ptr +: N_REQ];
        any_req = |req;
        off     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = IDX_W'(k);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_WIDE) sum = sum - N_WIDE;
        winner = sum[IDX_W-1:0];
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for a shared FIFO. Credits track free FIFO
// slots locally so the one-cycle-late full flag is never needed.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                         clk,
    input  logic                         rst_n,
    fifo_wr_arbiter_if.slave             bus,
    output logic                         grant_valid,
    output logic [$clog2(N_REQ)-1:0]     grant_id,
    output logic [$clog2(FIFO_DEPTH):0]  credit_cnt,
    output logic                         err_pop
);
    localparam int GID_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CRED_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [8:0]       BURST_LIM = 9'(MAX_BURST);

    // Saturating credit update: a write consumes a slot, a pop returns one.
    function automatic logic [CNT_W-1:0] credit_next(
        input logic [CNT_W-1:0] cnt,
        input logic             take,
        input logic             give
    );
        logic [CNT_W-1:0] res;
        res = cnt;
        if (take && !give && cnt != '0)        res = cnt - CNT_W'(1);
        else if (give && !take && cnt != CRED_FULL) res = cnt + CNT_W'(1);
        return res;
    endfunction

    // Next round-robin start point: the requester after the one just served.
    function automatic logic [GID_W-1:0] ptr_after(input logic [GID_W-1:0] id);
        return (id == GID_W'(N_REQ - 1)) ? '0 : id + GID_W'(1);
    endfunction

    arb_state_t        state;
    logic [GID_W-1:0]  rr_ptr;
    logic [GID_W-1:0]  winner;
    logic              any_req;
    logic [7:0]        beat_cnt;
    logic [N_REQ-1:0]  ready;
    logic              xfer;
    logic              burst_end;
    logic              pop_ok;
    logic [DATA_W-1:0] sel_data;
    logic              vld_p1;
    logic [DATA_W-1:0] wr_data_p1;

    fifo_wr_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (GID_W)
    ) u_rr_pick (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // Only the granted requester sees ready, and only while a slot is free.
    always_comb begin
        ready = '0;
        if (state == BURST && credit_cnt != '0) ready[grant_id] = 1'b1;
    end

    assign bus.req_ready = ready;

    // Handshake decode for the granted requester.
    always_comb begin
        xfer      = bus.req_valid[grant_id] & ready[grant_id];
        sel_data  = bus.req_data[int'(grant_id)*DATA_W +: DATA_W];
        burst_end = xfer & (bus.req_last[grant_id] |
                            (({1'b0, beat_cnt} + 9'd1) == BURST_LIM));
        pop_ok    = bus.fifo_rd_pop & (credit_cnt != CRED_FULL);
    end

    // Grant FSM: pick a winner in IDLE, count beats in BURST, release on last
    // beat or when the burst cap is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            beat_cnt    <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state       <= BURST;
                        grant_id    <= winner;
                        grant_valid <= 1'b1;
                        beat_cnt    <= '0;
                    end
                end
                BURST: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (burst_end) begin
                            state       <= IDLE;
                            grant_valid <= 1'b0;
                            rr_ptr      <= ptr_after(grant_id);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Free-slot credits and the sticky pop-while-empty error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_cnt <= CRED_FULL;
            err_pop    <= 1'b0;
        end else begin
            credit_cnt <= credit_next(credit_cnt, xfer, pop_ok);
            if (bus.fifo_rd_pop && credit_cnt == CRED_FULL) err_pop <= 1'b1;
        end
    end

    // Stage p1: registered FIFO write, one cycle after the accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            wr_data_p1 <= '0;
        end else begin
            vld_p1 <= xfer;
            if (xfer) wr_data_p1 <= sel_data;
        end
    end

    assign bus.fifo_wr_en = vld_p1;
    assign bus.fifo_d_in  = wr_data_p1;

endmodule
